fpu_sequencer: RTL and testbench

//  Two-requester front end for the combinational fpu datapath (a_operand, b_operand, operation -> ieee_packet_out).

---
 rtl/pa_fpu.sv | 44 ++++
 rtl/fpu_sequencer_fpu.sv | 103 ++++++++++
 rtl/fpu_sequencer.sv | 141 ++++++++++++++
 tb/tb_fpu_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu.sv
// Shared FPU types: op codes, sequencer states, result class flags.
// Also hosts the flag classifier used on captured results.
package pa_fpu;

    typedef enum logic [1:0] {
        op_add,
        op_sub,
        op_mul,
        op_div
    } e_fpu_op;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } e_seq_state;

    typedef struct packed {
        logic unsupp;
        logic nan;
        logic inf;
        logic zero;
        logic subnormal;
    } st_fpu_flags;

    localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

    function automatic st_fpu_flags classify(input logic [31:0] v);
        st_fpu_flags f;
        logic        e_max;
        logic        e_min;
        logic        m_nz;
        e_max       = (v[30:23] == 8'hFF);
        e_min       = (v[30:23] == 8'h00);
        m_nz        = (v[22:0] != 23'd0);
        f.unsupp    = 1'b0;
        f.nan       = e_max && m_nz;
        f.inf       = e_max && !m_nz;
        f.zero      = e_min && !m_nz;
        f.subnormal = e_min && m_nz;
        return f;
    endfunction

endpackage

// File: rtl/fpu_sequencer_fpu.sv
// Combinational IEEE-754 single add/sub, round-to-nearest-even.
// Ops mul/div yield the quiet NaN.
module fpu
    import pa_fpu::*;
(
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  e_fpu_op     operation,
    output logic [31:0] ieee_packet_out
);

    logic        sa, sb, sl, ss, sr;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap, g, st;
    logic [9:0]  el, es, ex, sh;
    logic [26:0] ml, ms, al;
    logic [27:0] r;
    logic [4:0]  lz;
    logic [24:0] mr;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    always_comb begin
        sa    = a_operand[31];
        sb    = b_operand[31] ^ (operation == op_sub);
        ea    = a_operand[30:23];
        eb    = b_operand[30:23];
        fa    = a_operand[22:0];
        fb    = b_operand[22:0];
        a_nan = (ea == 8'hFF) && (fa != 23'd0);
        b_nan = (eb == 8'hFF) && (fb != 23'd0);
        a_inf = (ea == 8'hFF) && (fa == 23'd0);
        b_inf = (eb == 8'hFF) && (fb == 23'd0);

        swap = {eb, fb} > {ea, fa};
        sl   = swap ? sb : sa;
        ss   = swap ? sa : sb;
        el   = {2'b00, swap ? eb : ea};
        es   = {2'b00, swap ? ea : eb};
        ml   = {el != 10'd0, swap ? fb : fa, 3'b000};
        ms   = {es != 10'd0, swap ? fa : fb, 3'b000};
        if (el == 10'd0) el = 10'd1;
        if (es == 10'd0) es = 10'd1;

        // Align the smaller operand; shifted-out bits fold into a sticky bit.
        sh = el - es;
        if (sh >= 10'd27) begin
            al = 27'd0;
            st = |ms;
        end else begin
            al = ms >> sh;
            st = |(ms & ~(27'h7FFFFFF << sh));
        end
        al[0] = al[0] | st;

        if (sl == ss) r = {1'b0, ml} + {1'b0, al};
        else          r = {1'b0, ml} - {1'b0, al};

        ex = el;
        lz = lzc27(r[26:0]);
        if (r[27]) begin
            r  = {1'b0, r[27:2], r[1] | r[0]};
            ex = ex + 10'd1;
        end else begin
            // Never normalise below exponent 1: that is the subnormal range.
            sh = ({5'd0, lz} < ex - 10'd1) ? {5'd0, lz} : ex - 10'd1;
            r  = r << sh;
            ex = ex - sh;
        end

        g  = r[2];
        st = r[1] | r[0];
        mr = {1'b0, r[26:3]} + {24'd0, g & (st | r[3])};
        if (mr[24]) begin
            mr = mr >> 1;
            ex = ex + 10'd1;
        end
        sr = ((mr == 25'd0) && (sl != ss)) ? 1'b0 : sl;

        if (operation == op_mul || operation == op_div)
            ieee_packet_out = FPU_QNAN;
        else if (a_nan || b_nan || (a_inf && b_inf && sa != sb))
            ieee_packet_out = FPU_QNAN;
        else if (a_inf)
            ieee_packet_out = {sa, 8'hFF, 23'd0};
        else if (b_inf)
            ieee_packet_out = {sb, 8'hFF, 23'd0};
        else if (ex >= 10'd255)
            ieee_packet_out = {sr, 8'hFF, 23'd0};
        else
            ieee_packet_out = {sr, mr[23] ? ex[7:0] : 8'd0, mr[22:0]};
    end

endmodule

// File: rtl/fpu_sequencer.sv
// Two-requester round-robin front end for the combinational fpu.
// Latches operands, lets the datapath settle, captures and returns.
module fpu_sequencer
    import pa_fpu::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  e_fpu_op     req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  e_fpu_op     req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        busy
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    e_seq_state  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    e_fpu_op     op_q, op_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic        vld_q, vld_d;
    logic [31:0] res_q, res_d;
    st_fpu_flags flg_q, flg_d;

    logic        take, gnt_id, unsupp;
    logic [31:0] dp_out, cap;
    st_fpu_flags cap_flg;

    fpu fpu_dp (
        .a_operand       (a_q),
        .b_operand       (b_q),
        .operation       (op_q),
        .ieee_packet_out (dp_out)
    );

    always_comb begin
        take = (state_q == IDLE) && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) gnt_id = ~last_q;
        else                          gnt_id = req1_valid;
        req0_ready = take && !gnt_id;
        req1_ready = take && gnt_id;
    end

    always_comb begin
        unsupp         = (op_q == op_mul) || (op_q == op_div);
        cap            = unsupp ? FPU_QNAN : dp_out;
        cap_flg        = classify(cap);
        cap_flg.unsupp = unsupp;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;
        vld_d   = vld_q;
        res_d   = res_q;
        flg_d   = flg_q;
        unique case (state_q)
            IDLE: begin
                if (take) begin
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
                    op_d    = gnt_id ? req1_op : req0_op;
                    id_d    = gnt_id;
                    cnt_d   = 4'd0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    res_d   = cap;
                    flg_d   = cap_flg;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    last_d  = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= op_add;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            vld_q   <= 1'b0;
            res_q   <= 32'd0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign rsp_valid  = vld_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flg_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench: stimulus pushes expected responses,
// a negedge monitor pops and compares on each handshake.
module tb_fpu_sequencer;
    import pa_fpu::*;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    e_fpu_op     req0_op = op_add, req1_op = op_add;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_v = 1'b0;

    fpu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    always @(negedge clk) begin
        if (!arst_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v)
                chk("latency", 64'(cyc - acc_cyc), 64'(SETTLE));
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    timeout("unexpected_rsp");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_result", 64'(rsp_result), 64'(e.res));
                    chk("rsp_flags", 64'(rsp_flags), 64'(e.flg));
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic drive(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input e_fpu_op op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    task automatic wait_rdy(input logic id, output logic ok);
        ok = 1'b0;
        #1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (id ? req1_ready : req0_ready) ok = 1'b1;
            else begin @(posedge clk); #2; end
        end
        if (!ok) timeout("grant_wait");
    endtask

    task automatic push(input logic id, input logic [31:0] r,
                        input logic [4:0] f);
        exp_t e;
        e.id = id; e.res = r; e.flg = f;
        sb_q.push_back(e);
    endtask

    task automatic accept();
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic issue(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input e_fpu_op op,
                         input logic do_push, input logic [31:0] er,
                         input logic [4:0] ef);
        logic ok;
        drive(id, a, b, op);
        wait_rdy(id, ok);
        if (ok && do_push) push(id, er, ef);
        accept();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) timeout("drain");
    endtask

    initial begin
        logic ok;
        logic g;

        #3;
        chk("reset_outputs",
            {26'd0, rsp_valid, rsp_id, rsp_result, rsp_flags, busy},
            64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 32'h00000001, 32'h00000001, op_add, 1, 32'h00000002, 5'b00001);
        issue(1, 32'h007FFFFF, 32'h00000001, op_add, 1, 32'h00800000, 5'b00000);
        issue(1, 32'h00000001, 32'h80000001, op_sub, 1, 32'h00000002, 5'b00001);

        drive(0, 32'h3F800000, 32'h40000000, op_add);
        drive(1, 32'h40400000, 32'h3F800000, op_sub);
        for (int k = 0; k < 4; k++) begin
            ok = 1'b0;
            #1;
            for (int i = 0; i < 60 && !ok; i++) begin
                if (req0_ready || req1_ready) ok = 1'b1;
                else begin @(posedge clk); #2; end
            end
            if (!ok) begin
                timeout("rr_grant_wait");
            end else begin
                g = req1_ready;
                chk("rr_grant", {62'd0, req1_ready, req0_ready},
                    (k % 2 == 0) ? 64'd1 : 64'd2);
                if (g) push(1, 32'h40000000, 5'b00000);
                else   push(0, 32'h40400000, 5'b00000);
            end
            accept();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();

        rsp_ready = 1'b0;
        issue(0, 32'h3F800000, 32'h3F800000, op_add, 1, 32'h40000000, 5'b00000);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rsp_valid) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) timeout("held_valid_wait");
        drive(0, 32'h00000001, 32'h00000001, op_add);
        drive(1, 32'h00000001, 32'h00000001, op_add);
        repeat (10) begin
            @(posedge clk); #1;
            chk("held_stable",
                {23'd0, rsp_valid, rsp_id, rsp_result, rsp_flags,
                 req0_ready, req1_ready},
                {23'd0, 1'b1, 1'b0, 32'h40000000, 5'b00000, 2'b00});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #2;
        chk("post_release_grant", {62'd0, req0_ready, req1_ready}, 64'd1);
        if (req1_ready) push(1, 32'h00000002, 5'b00001);
        accept();
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        issue(0, 32'h7F800000, 32'h41200000, op_add, 1, 32'h7F800000, 5'b00100);
        issue(0, 32'h3F800000, 32'h40000000, op_mul, 1, 32'h7FC00000, 5'b11000);
        drain();

        issue(0, 32'h3F800000, 32'h3F800000, op_add, 0, 32'h0, 5'b0);
        arst_n = 1'b0;
        #1;
        chk("abort_state", {62'd0, rsp_valid, busy}, 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        drive(0, 32'h40000000, 32'h40000000, op_add);
        drive(1, 32'h00000001, 32'h00000001, op_add);
        #1;
        chk("rst_first_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
        if (req0_ready) push(0, 32'h40800000, 5'b00000);
        accept();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
